// File: rtl/piezo_alert_sched.sv
`default_nettype none
// ============================================================================
//  Module   : piezo_alert_sched
//  Purpose  : Priority scheduler for the shared piezo tone player. It picks one
//             alert, issues start/abort pulses, rate-limits the non-urgent
//             tunes and enforces a silent gap after each tune.
//  Options  : PIEZO_PREEMPT_EN - too_fast preempts a running BATT/STEER tune.
//  Revision : 1.0 - initial release
// ============================================================================
module piezo_alert_sched #(
    parameter int REPEAT_CYC = 150000000,
    parameter int GAP_CYC    = 2500000,
    parameter int PLAY_TO    = 200000000,
    parameter int CNT_W      = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       too_fast,
    input  logic       batt_low,
    input  logic       en_steer,
    input  logic       tune_done,
    output logic       tune_start,
    output logic [1:0] tune_sel,
    output logic       tune_abort,
    output logic       busy,
    output logic [7:0] alert_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [1:0]       C_SEL_NONE  = 2'b00;
    localparam logic [1:0]       C_SEL_FAST  = 2'b01;
    localparam logic [1:0]       C_SEL_BATT  = 2'b10;
    localparam logic [1:0]       C_SEL_STEER = 2'b11;
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_REP_LD    = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_TO_LD     = CNT_W'(PLAY_TO - 1);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_tune_sel;
    logic [1:0]       w_sel_next;
    logic [1:0]       w_pick;
    logic             r_tune_start;
    logic             r_tune_abort;
    logic             w_abort_next;
    logic             r_busy;
    logic [7:0]       r_alert_cnt;
    logic [CNT_W-1:0] r_rep_tmr;
    logic [CNT_W-1:0] r_gap_tmr;
    logic [CNT_W-1:0] r_to_tmr;
    logic             w_preempt;
    logic             w_pre_pend;

    // too_fast is never rate-limited; the other two wait for the repeat timer.
    always_comb begin
        w_pick = C_SEL_NONE;
        if (too_fast) begin
            w_pick = C_SEL_FAST;
        end else if (r_rep_tmr == '0) begin
            if (batt_low) begin
                w_pick = C_SEL_BATT;
            end else if (en_steer) begin
                w_pick = C_SEL_STEER;
            end
        end
    end

`ifdef PIEZO_PREEMPT_EN
    // The abort pulse is issued while still in PLAY; an abort seen in PLAY
    // therefore marks a pending preemption and START follows on the next edge.
    assign w_preempt  = (r_state == S_PLAY) && (r_tune_sel != C_SEL_FAST) &&
                        too_fast && !r_tune_abort;
    assign w_pre_pend = (r_state == S_PLAY) && r_tune_abort;
`else
    assign w_preempt  = 1'b0;
    assign w_pre_pend = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_sel_next   = r_tune_sel;
        w_abort_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel_next = w_pick;
                if (w_pick != C_SEL_NONE) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_next = S_PLAY;
            end
            S_PLAY: begin
                if (w_pre_pend) begin
                    w_next     = S_START;
                    w_sel_next = C_SEL_FAST;
                end else if (w_preempt) begin
                    w_abort_next = 1'b1;
                end else if (tune_done) begin
                    w_next     = S_GAP;
                    w_sel_next = C_SEL_NONE;
                end else if (r_to_tmr == '0) begin
                    w_next       = S_GAP;
                    w_sel_next   = C_SEL_NONE;
                    w_abort_next = 1'b1;
                end
            end
            S_GAP: begin
                w_sel_next = C_SEL_NONE;
                if (r_gap_tmr == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_sel_next = C_SEL_NONE;
            end
        endcase
    end

    // START actions happen on the edge entering START so they are visible
    // in the same cycle as the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tune_sel   <= C_SEL_NONE;
            r_tune_start <= 1'b0;
            r_tune_abort <= 1'b0;
            r_busy       <= 1'b0;
            r_alert_cnt  <= 8'd0;
            r_rep_tmr    <= '0;
            r_gap_tmr    <= '0;
            r_to_tmr     <= '0;
        end else begin
            r_state      <= w_next;
            r_tune_sel   <= w_sel_next;
            r_tune_abort <= w_abort_next;
            r_tune_start <= (w_next == S_START);
            r_busy       <= (w_next != S_IDLE);
            if (w_next == S_START) begin
                if (r_alert_cnt != 8'hFF) begin
                    r_alert_cnt <= r_alert_cnt + 8'd1;
                end
                r_rep_tmr <= C_REP_LD;
                r_to_tmr  <= C_TO_LD;
            end else begin
                if (r_rep_tmr != '0) begin
                    r_rep_tmr <= r_rep_tmr - C_ONE;
                end
                if (r_to_tmr != '0) begin
                    r_to_tmr <= r_to_tmr - C_ONE;
                end
            end
            if ((r_state == S_PLAY) && (w_next == S_GAP)) begin
                r_gap_tmr <= C_GAP_LD;
            end else if (r_gap_tmr != '0) begin
                r_gap_tmr <= r_gap_tmr - C_ONE;
            end
        end
    end

    assign tune_start = r_tune_start;
    assign tune_sel   = r_tune_sel;
    assign tune_abort = r_tune_abort;
    assign busy       = r_busy;
    assign alert_cnt  = r_alert_cnt;

endmodule
`default_nettype wire

// File: tb/tb_piezo_alert_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piezo_alert_sched
//  Purpose  : Self-checking bench for piezo_alert_sched against a timestamp
//             based reference model, with directed and random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piezo_alert_sched;

    localparam int REP = 100;
    localparam int GAP = 4;
    localparam int PTO = 50;
`ifdef PIEZO_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       too_fast = 1'b0;
    logic       batt_low = 1'b0;
    logic       en_steer = 1'b0;
    logic       tune_done = 1'b0;
    logic       tune_start;
    logic [1:0] tune_sel;
    logic       tune_abort;
    logic       busy;
    logic [7:0] alert_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a tune is described by its start cycle and the cycle
    // the piezo becomes idle again, rather than by an explicit state.
    bit m_in_tune = 1'b0;
    int m_t_start = -1000000;
    int m_idle_at = 0;
    bit m_pend    = 1'b0;
    int m_cnt     = 0;
    int e_start, e_sel, e_abort, e_busy, e_cnt;

    piezo_alert_sched #(
        .REPEAT_CYC (REP),
        .GAP_CYC    (GAP),
        .PLAY_TO    (PTO),
        .CNT_W      (28)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .too_fast   (too_fast),
        .batt_low   (batt_low),
        .en_steer   (en_steer),
        .tune_done  (tune_done),
        .tune_start (tune_start),
        .tune_sel   (tune_sel),
        .tune_abort (tune_abort),
        .busy       (busy),
        .alert_cnt  (alert_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic begin_tune(input int t, input int s);
        m_in_tune = 1'b1;
        m_t_start = t;
        e_start   = 1;
        e_sel     = s;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic end_tune(input int c);
        m_in_tune = 1'b0;
        m_idle_at = c + 1 + GAP;
        e_sel     = 0;
    endtask

    // Predicts the outputs visible after the coming edge from this cycle's inputs.
    task automatic model_next();
        int c;
        int pick;
        c       = cyc;
        e_start = 0;
        e_abort = 0;
        if (rst) begin
            e_sel     = 0;
            e_busy    = 0;
            e_cnt     = 0;
            m_cnt     = 0;
            m_in_tune = 1'b0;
            m_idle_at = c + 1;
            m_t_start = -1000000;
            m_pend    = 1'b0;
            return;
        end
        if (!m_in_tune && c >= m_idle_at) begin
            pick = 0;
            if (too_fast) pick = 1;
            else if (c - m_t_start >= REP - 1) begin
                if (batt_low)      pick = 2;
                else if (en_steer) pick = 3;
            end
            e_sel = pick;
            if (pick != 0) begin_tune(c + 1, pick);
        end else if (m_in_tune && c > m_t_start) begin
            if (m_pend) begin
                m_pend = 1'b0;
                begin_tune(c + 1, 1);
            end else if (PRE && e_sel != 1 && too_fast) begin
                e_abort = 1;
                m_pend  = 1'b1;
            end else if (tune_done) begin
                end_tune(c);
            end else if (c - m_t_start == PTO - 1) begin
                e_abort = 1;
                end_tune(c);
            end
        end else if (!m_in_tune) begin
            e_sel = 0;
        end
        e_busy = (m_in_tune || (c + 1 < m_idle_at)) ? 1 : 0;
        e_cnt  = m_cnt;
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        cyc++;
        chk("start", tune_start, e_start);
        chk("sel",   tune_sel,   e_sel);
        chk("abort", tune_abort, e_abort);
        chk("busy",  busy,       e_busy);
        chk("cnt",   alert_cnt,  e_cnt);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic pulse_done_after_start();
        tune_done = 1'b1;
        step();
        step();
        tune_done = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int t0, td, ts, ta, n, nst, cnt0;

        // Reset, then a STEER tune finished by tune_done, then the repeat gate
        rst = 1'b1;
        step();
        step();
        rst      = 1'b0;
        en_steer = 1'b1;
        step();
        chk("a_first_start", tune_start, 1);
        chk("a_first_sel", tune_sel, 3);
        t0 = cyc;
        while (cyc < t0 + 10) step();
        tune_done = 1'b1;
        td = cyc;
        step();
        tune_done = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("a_idle_after_done", cyc - td, GAP + 1);
        n = 0;
        while (!tune_start && n < 200) begin
            step();
            n++;
        end
        chk("a_repeat_interval", cyc - t0, REP);
        chk("a_alert_cnt", alert_cnt, 2);
        en_steer = 1'b0;
        repeat (130) step();

        // Priority between simultaneous requests
        batt_low = 1'b1;
        en_steer = 1'b1;
        step();
        chk("b_batt_over_steer", tune_sel, 2);
        batt_low = 1'b0;
        en_steer = 1'b0;
        pulse_done_after_start();
        wait_idle("b_idle1");
        too_fast = 1'b1;
        batt_low = 1'b1;
        en_steer = 1'b1;
        step();
        chk("b_fast_over_all", tune_sel, 1);
        too_fast = 1'b0;
        batt_low = 1'b0;
        en_steer = 1'b0;
        pulse_done_after_start();
        wait_idle("b_idle2");

        // too_fast held through the gap of a STEER tune
        repeat (110) step();
        en_steer = 1'b1;
        step();
        chk("c_steer_sel", tune_sel, 3);
        en_steer = 1'b0;
        pulse_done_after_start();
        too_fast = 1'b1;
        n = 0;
        while (busy && n < 10) begin
            chk("c_no_start_in_gap", tune_start, 0);
            step();
            n++;
        end
        step();
        chk("c_fast_start", tune_start, 1);
        chk("c_fast_sel", tune_sel, 1);
        too_fast = 1'b0;
        pulse_done_after_start();
        wait_idle("c_idle");

        // Timeout watchdog with a late tune_done
        repeat (110) step();
        batt_low = 1'b1;
        step();
        ts = cyc;
        batt_low = 1'b0;
        n = 0;
        while (!tune_abort && n < 80) begin
            step();
            n++;
        end
        chk("d_abort_latency", cyc - ts, PTO);
        ta = cyc;
        step();
        step();
        tune_done = 1'b1;
        step();
        tune_done = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("d_busy_drop", cyc - ta, GAP);

        // too_fast raised five cycles into a BATT tune
        repeat (110) step();
        batt_low = 1'b1;
        step();
        batt_low = 1'b0;
        cnt0 = m_cnt;
        repeat (5) step();
        too_fast = 1'b1;
        step();
`ifdef PIEZO_PREEMPT_EN
        chk("e_pre_abort", tune_abort, 1);
        chk("e_pre_no_start_yet", tune_start, 0);
        step();
        chk("e_pre_start", tune_start, 1);
        chk("e_pre_sel", tune_sel, 1);
        chk("e_pre_cnt", alert_cnt, cnt0 + 1);
`else
        chk("e_no_abort", tune_abort, 0);
        step();
        chk("e_no_abort2", tune_abort, 0);
        chk("e_sel_kept", tune_sel, 2);
`endif
        too_fast = 1'b0;
        tune_done = 1'b1;
        step();
        step();
        tune_done = 1'b0;
        wait_idle("e_idle");

        // Randomised traffic including occasional resets
        for (int i = 0; i < 3000; i++) begin
            too_fast  = ($urandom_range(0, 19) == 0);
            batt_low  = ($urandom_range(0, 3) == 0);
            en_steer  = ($urandom_range(0, 2) == 0);
            tune_done = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            step();
        end
        too_fast  = 1'b0;
        batt_low  = 1'b0;
        en_steer  = 1'b0;
        tune_done = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;

        // Back-to-back FAST tunes saturate the counter; reset mid-PLAY
        too_fast  = 1'b1;
        tune_done = 1'b1;
        nst = 0;
        n   = 0;
        while (nst < 300 && n < 4000) begin
            step();
            if (tune_start) nst++;
            n++;
        end
        chk("g_start_count", nst, 300);
        chk("g_cnt_saturated", alert_cnt, 255);
        tune_done = 1'b0;
        n = 0;
        step();
        while (!tune_start && n < 100) begin
            step();
            n++;
        end
        chk("g_restart_seen", tune_start, 1);
        step();
        rst = 1'b1;
        step();
        chk("g_rst_start", tune_start, 0);
        chk("g_rst_sel", tune_sel, 0);
        chk("g_rst_abort", tune_abort, 0);
        chk("g_rst_busy", busy, 0);
        chk("g_rst_cnt", alert_cnt, 0);
        rst      = 1'b0;
        too_fast = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
